// File: rtl/breath_sched.sv
//------------------------------------------------------------------------------
// Module  : breath_sched
// Brief   : Round-robin breathing-LED scheduler for four active-low channels.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module breath_sched #(
    parameter int CNT_1US_MAX = 49,
    parameter int PWM_MAX     = 999,
    parameter int GAP_PERIODS = 200
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] chan_mask,
    output logic       busy,
    output logic [1:0] cur_chan,
    output logic       chan_done,
    output logic [3:0] led_out
);

    localparam int c_CNT_W = (CNT_1US_MAX > 0) ? $clog2(CNT_1US_MAX + 1) : 1;
    localparam int c_PWM_W = (PWM_MAX > 0) ? $clog2(PWM_MAX + 1) : 1;
    localparam int c_GAP_W = (GAP_PERIODS > 1) ? $clog2(GAP_PERIODS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_FALL = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_PWM_W-1:0]   r_pwm;
    logic [c_PWM_W-1:0]   r_duty;
    logic [c_GAP_W-1:0]   r_gap;
    logic [1:0]           r_cur;
    logic                 r_busy;
    logic                 r_done;
    logic [3:0]           r_led;

    logic                 w_tick;
    logic                 w_pend;
    logic [2:0]           w_first;
    logic [2:0]           w_next;
    logic [3:0]           w_led;

    // Returns {found, index}: first set bit searching cur+1, cur+2, cur+3, cur.
    // Iterating farthest-first lets the nearest hit overwrite the others.
    function automatic logic [2:0] f_pick(input logic [3:0] mask, input logic [1:0] cur);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (mask[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign w_tick  = (r_state != S_IDLE) && (r_cnt == c_CNT_W'(CNT_1US_MAX));
    assign w_pend  = w_tick && (r_pwm == c_PWM_W'(PWM_MAX));
    assign w_first = f_pick(chan_mask, 2'd3);
    assign w_next  = f_pick(chan_mask, r_cur);

    always_comb begin
        w_led = 4'hF;
        if ((r_state == S_RISE || r_state == S_FALL) && (r_pwm < r_duty))
            w_led[r_cur] = 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pwm   <= '0;
            r_duty  <= '0;
            r_gap   <= '0;
            r_cur   <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_led   <= 4'hF;
        end else begin
            r_done <= 1'b0;
            r_led  <= w_led;
            if (r_state == S_IDLE) begin
                r_cnt  <= '0;
                r_pwm  <= '0;
                r_duty <= '0;
                if (start && !stop && (chan_mask != 4'h0)) begin
                    r_state <= S_RISE;
                    r_cur   <= w_first[1:0];
                    r_busy  <= 1'b1;
                end
            end else if (stop) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_pwm   <= '0;
                r_duty  <= '0;
                r_gap   <= '0;
                r_busy  <= 1'b0;
                r_led   <= 4'hF;
            end else begin
                if (w_tick) begin
                    r_cnt <= '0;
                    r_pwm <= (r_pwm == c_PWM_W'(PWM_MAX)) ? '0 : r_pwm + 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_pend) begin
                    case (r_state)
                        S_RISE: begin
                            if (r_duty == c_PWM_W'(PWM_MAX)) r_state <= S_FALL;
                            else                             r_duty  <= r_duty + 1'b1;
                        end
                        S_FALL: begin
                            if (r_duty == '0) begin
                                r_state <= S_GAP;
                                r_done  <= 1'b1;
                                r_gap   <= '0;
                            end else begin
                                r_duty <= r_duty - 1'b1;
                            end
                        end
                        S_GAP: begin
                            if (r_gap == c_GAP_W'(GAP_PERIODS - 1)) begin
                                r_gap  <= '0;
                                r_duty <= '0;
                                if (w_next[2]) begin
                                    r_state <= S_RISE;
                                    r_cur   <= w_next[1:0];
                                end else begin
                                    r_state <= S_IDLE;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_gap <= r_gap + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign busy      = r_busy;
    assign cur_chan  = r_cur;
    assign chan_done = r_done;
    assign led_out   = r_led;

endmodule

`default_nettype wire

// File: doc/breath_sched.md
# breath_sched

Round-robin breathing-LED scheduler for up to four LED channels. It generates a shared 1 µs tick, a PWM period counter and a triangular duty ramp, then grants the ramp to one enabled channel at a time: fade in, fade out, dark gap, then the next channel. It sits between the board's key/command logic (`start`, `stop`, `chan_mask`) and the active-low LED pins.

## Interface

Parameters:
- `CNT_1US_MAX`, default 49: system clocks per µs tick minus 1.
- `PWM_MAX`, default 999: µs ticks per PWM period minus 1. Also the maximum duty value.
- `GAP_PERIODS`, default 200: number of dark PWM periods between channels (must be ≥ 1).

Ports:
- `sys_clk` in 1: the only clock. Everything is on the rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin the sequence.
- `stop` in 1: single-cycle request to abort.
- `chan_mask` in 4: channel enables, bit i enables LED i.
- `busy` out 1: high while the sequence runs (state ≠ IDLE).
- `cur_chan` out 2: index of the channel that currently owns the ramp.
- `chan_done` out 1: one-cycle pulse when a channel finishes its fade-out.
- `led_out` out 4: active-low LED drive (0 = on).

## Operation

- **States:** IDLE, RISE, FALL, GAP.
- **Reset values:** state IDLE, `led_out`=4'hF, `busy`=0, `chan_done`=0, `cur_chan`=0. All counters are 0.
- **`cnt_us` (0..CNT_1US_MAX):**
  - Runs only outside IDLE; held at 0 in IDLE.
  - `tick_us` = (`cnt_us`==CNT_1US_MAX).
- **`pwm_pos` (0..PWM_MAX):**
  - Advances on `tick_us` and wraps to 0.
  - `period_end` = `tick_us` && `pwm_pos`==PWM_MAX.
- **`duty` (0..PWM_MAX):**
  - Changes only on `period_end`.
  - It can never underflow or overflow.
- **IDLE → RISE:** on `start`=1, `stop`=0 and `chan_mask`≠0.
  - `cur_chan` loads the lowest set bit of `chan_mask`.
  - `duty`, `cnt_us` and `pwm_pos` load 0.
  - `start` with `chan_mask`=0 is ignored.
- **RISE:** on `period_end`, if `duty`==PWM_MAX go to FALL with `duty` unchanged; otherwise `duty`+1.
- **FALL:** on `period_end`, if `duty`==0 go to GAP, pulse `chan_done`, and clear the gap counter; otherwise `duty`−1.
- **GAP:**
  - The gap counter counts `period_end` events.
  - On the GAP_PERIODS-th one, select the next channel: the first set bit of the current `chan_mask`, searching `cur_chan`+1, +2, +3, then `cur_chan` itself, modulo 4.
  - If a channel is found, load it into `cur_chan`, set `duty`=0 and go to RISE.
  - If `chan_mask`=0, go to IDLE.
  - `chan_mask` is sampled only at start and at this handover; changes at other times have no effect.
- **`stop`:** in any non-IDLE state, the next state is IDLE, and counters and `duty` clear.
  - `stop` beats `start` in the same cycle.
  - `start` while `busy` is ignored.
- **LED drive:**
  - In RISE/FALL, `led_out[cur_chan]` = 0 when `pwm_pos` < `duty`, else 1.
  - All other bits are 1, and all bits are 1 in IDLE and GAP.
  - Duty 0 means fully off. Duty PWM_MAX means on for PWM_MAX of PWM_MAX+1 positions, so the LED is never 100% on.

## Timing

- All outputs are registered.
- `led_out` reflects counter/state values of the previous cycle (1-cycle lag).
- `busy` rises the cycle after accepted `start` and falls the cycle after `stop` or the final handover.
- After `stop`, `led_out` reads 4'hF on the next cycle and stays there.
- `chan_done` is high for exactly the cycle after the FALL→GAP `period_end`.
- PWM period = (PWM_MAX+1)·(CNT_1US_MAX+1) clocks.
- Per channel:
  - RISE lasts PWM_MAX+1 periods.
  - FALL lasts PWM_MAX+1 periods.
  - GAP lasts GAP_PERIODS periods.
- `cur_chan` updates on the same edge as the GAP→RISE transition.
- Reset asserted mid-sequence returns every output to its reset value on the next edge, regardless of state.

## Test plan

All scenarios use CNT_1US_MAX=1, PWM_MAX=3, GAP_PERIODS=2, so a period is 8 clocks and a channel takes 80 clocks.

1. **Basic single channel.** `chan_mask`=4'b0100, pulse `start`.
   - `busy`=1 and `cur_chan`=2 on the next cycle.
   - Per-period low-time of `led_out[2]` is 0,2,4,6 (RISE) then 6,4,2,0 (FALL) clocks.
   - `chan_done` pulses 64 clocks after start.
   - RISE restarts on channel 2 after 16 dark clocks.
2. **Round robin with wrap.** `chan_mask`=4'b1010.
   - `cur_chan` sequence is 1,3,1,3 with 80-clock spacing.
   - Bits 0 and 2 stay 1 throughout.
3. **Stop mid-FALL.** Pulse `stop` while in FALL.
   - `led_out`=4'hF and `busy`=0 the next cycle.
   - A later `start` begins from `duty` 0 on the lowest enabled channel.
4. **Simultaneous events.**
   - `start`+`stop` together in IDLE: stays IDLE.
   - `start` with `chan_mask`=0: ignored.
   - `start` while busy: no restart.
5. **Mask cleared mid-sequence.** Clear `chan_mask` during RISE.
   - The current channel completes its RISE, FALL and GAP.
   - Then the block returns to IDLE with `busy`=0.
6. **Reset mid-RISE.** Assert `sys_rst` for one cycle during RISE.
   - All outputs are at reset values the next cycle (`led_out`=4'hF).
   - No `chan_done` pulse appears.
